// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage, the ALU and the control decoder.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int CNT_W_DEF   = 16;
    localparam int ALUCON_W    = 4;

    // ALU operation encodings, shared with the ALU and the decoder
    typedef enum logic [ALUCON_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_MUL = 4'd2,
        ALU_DIV = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_e;

    // Highest legal opcode; anything above it is flagged as an error
    localparam logic [ALUCON_W-1:0] ALU_MAX_OP = 4'd4;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: EX/MEM result first, then MEM/WB data, else the
// register-file value latched at decode. Register 0 is never forwarded.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic [RADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0]  src_data,
    input  logic               exmem_regwrite,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_regwrite,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]  memwb_data,
    output logic [DATA_W-1:0]  fwd_data
);

    logic ex_hit;
    logic wb_hit;

    assign ex_hit = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src_addr);
    assign wb_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src_addr);

    // Priority select: the younger EX/MEM producer wins over MEM/WB
    always_comb begin
        fwd_data = src_data;
        if (ex_hit)      fwd_data = exmem_result;
        else if (wb_hit) fwd_data = memwb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, stall/flush control,
// ALU opcode checking and a saturating stall counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic               in_regwrite,
    input  logic               in_alusrc,
    input  logic [3:0]         in_alucon,
    input  logic [RADDR_W-1:0] in_rs_addr,
    input  logic [RADDR_W-1:0] in_rt_addr,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic [DATA_W-1:0]  in_rs_data,
    input  logic [DATA_W-1:0]  in_rt_data,
    input  logic [DATA_W-1:0]  in_imm,
    input  logic               exmem_regwrite,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_regwrite,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]  memwb_data,
    output logic               ex_valid,
    output logic               ex_regwrite,
    output logic [3:0]         ex_alucon,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]  ex_data_a,
    output logic [DATA_W-1:0]  ex_data_b,
    output logic               op_error,
    output logic               div_zero,
    output logic [CNT_W-1:0]   stall_count
);

    logic [RADDR_W-1:0] rs_addr_q;
    logic [RADDR_W-1:0] rt_addr_q;
    logic [DATA_W-1:0]  rs_data_q;
    logic [DATA_W-1:0]  rt_data_q;
    logic [DATA_W-1:0]  imm_q;
    logic               alusrc_q;
    logic [DATA_W-1:0]  fwd_a;
    logic [DATA_W-1:0]  fwd_b;
    logic               wb_hold_rs;
    logic               wb_hold_rt;

    // A write-back retiring while we hold must be captured, or it is lost
    // once MEM/WB moves on before the stall releases.
    assign wb_hold_rs = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_addr_q);
    assign wb_hold_rt = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_addr_q);

    // Pipeline register: flush clears, stall holds (with write-back capture), else load
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_alucon   <= '0;
            ex_rd       <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            alusrc_q    <= 1'b0;
        end else if (stall) begin
            if (wb_hold_rs) rs_data_q <= memwb_data;
            if (wb_hold_rt) rt_data_q <= memwb_data;
        end else begin
            ex_valid    <= in_valid;
            ex_regwrite <= in_regwrite & in_valid;
            ex_alucon   <= in_alucon;
            ex_rd       <= in_rd_addr;
            rs_addr_q   <= in_rs_addr;
            rt_addr_q   <= in_rt_addr;
            rs_data_q   <= in_rs_data;
            rt_data_q   <= in_rt_data;
            imm_q       <= in_imm;
            alusrc_q    <= in_alusrc;
        end
    end

    // Count cycles a valid instruction spends stalled; saturate instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && !flush && ex_valid && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_a (
        .src_addr       (rs_addr_q),
        .src_data       (rs_data_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .fwd_data       (fwd_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_b (
        .src_addr       (rt_addr_q),
        .src_data       (rt_data_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .fwd_data       (fwd_b)
    );

    assign ex_data_a = fwd_a;
    assign ex_data_b = alusrc_q ? imm_q : fwd_b;
    assign op_error  = ex_valid && (ex_alucon > ALU_MAX_OP);
    assign div_zero  = ex_valid && (ex_alucon == ALU_DIV) && (ex_data_b == '0);

endmodule
